// File: rtl/seletor_modo_if.sv
// rtl/seletor_modo_if.sv - button inputs and mode-code outputs of the clock mode selector
interface seletor_modo_if;
  logic btn_modo;
  logic btn_ajuste;
  logic SW2;
  logic SW1;
  logic SW0;
  logic ajuste_ativo;
  logic troca;

  modport master (
    output btn_modo, btn_ajuste,
    input  SW2, SW1, SW0, ajuste_ativo, troca
  );

  modport slave (
    input  btn_modo, btn_ajuste,
    output SW2, SW1, SW0, ajuste_ativo, troca
  );
endinterface

// File: rtl/seletor_modo.sv
// rtl/seletor_modo.sv - two-button mode sequencer: sync, debounce, mode FSM, change pulse
// Optional adjust-mode inactivity return enabled by SELETOR_AUTO_RETORNO_EN.
module seletor_modo #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic          clk,
  input  logic          reset,
  seletor_modo_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("seletor_modo: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    RELOGIO    = 3'b000,
    CRONOMETRO = 3'b001,
    TIMER      = 3'b010,
    AJ_RELOGIO = 3'b100,
    AJ_TIMER   = 3'b110
  } modo_t;

  // index 0 = btn_modo, index 1 = btn_ajuste
  logic [1:0]    s1_q, s2_q, db_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    press;
  logic          press_m, press_a;
  logic          tmo_hit;
  modo_t         state_q;
  logic          troca_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= {bus.btn_ajuste, bus.btn_modo};
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_q[i]  <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      press[i] = s2_q[i] & ~db_q[i] & (cnt_q[i] == CNT_LAST);
  end

  assign press_a = press[1];
  // a mode press arriving together with an adjust press is dropped, not queued
  assign press_m = press[0] & ~press[1];

`ifdef SELETOR_AUTO_RETORNO_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q;

  // runs only while in an adjust mode; any press event restarts it
  assign tmo_hit = state_q[2] && (tmo_q == TMO_LAST) && (press == 2'b00);

  always_ff @(posedge clk) begin
    if (reset || (press != 2'b00) || !state_q[2] || tmo_hit)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELOGIO;
      troca_q <= 1'b0;
    end else begin
      troca_q <= 1'b0;
      case (state_q)
        RELOGIO: begin
          if (press_a) begin
            state_q <= AJ_RELOGIO;
            troca_q <= 1'b1;
          end else if (press_m) begin
            state_q <= CRONOMETRO;
            troca_q <= 1'b1;
          end
        end
        CRONOMETRO: begin
          if (press_m) begin
            state_q <= TIMER;
            troca_q <= 1'b1;
          end
        end
        TIMER: begin
          if (press_a) begin
            state_q <= AJ_TIMER;
            troca_q <= 1'b1;
          end else if (press_m) begin
            state_q <= RELOGIO;
            troca_q <= 1'b1;
          end
        end
        AJ_RELOGIO: begin
          if (press_a || tmo_hit) begin
            state_q <= RELOGIO;
            troca_q <= 1'b1;
          end
        end
        AJ_TIMER: begin
          if (press_a || tmo_hit) begin
            state_q <= TIMER;
            troca_q <= 1'b1;
          end
        end
        default: begin
          state_q <= RELOGIO;
          troca_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.SW2          = state_q[2];
  assign bus.SW1          = state_q[1];
  assign bus.SW0          = state_q[0];
  assign bus.ajuste_ativo = state_q[2];
  assign bus.troca        = troca_q;
endmodule

// File: tb/tb_seletor_modo.sv
// tb/tb_seletor_modo.sv - randomized and directed bench for seletor_modo against a behavioural model
module tb_seletor_modo;
  localparam int D = 4;
  localparam int T = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  seletor_modo_if ifc ();

  seletor_modo #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // model state: raw samples per button (bit 0 = newest edge), debounced levels, mode code
  bit [D+1:0] hist_m, hist_a;
  bit         mdb_m, mdb_a;
  int         m_mode;
  bit         m_troca;
  int         m_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // a level change is accepted once the D most recent synchronized samples all differ from it
  function automatic bit settled(input bit [D+1:0] h, input bit db);
    return h[D+1:2] == {D{~db}};
  endfunction

  function automatic int next_mode(input int mode, input bit pm, input bit pa, input bit to);
    case (mode)
      0:       return pa ? 4 : (pm ? 1 : 0);
      1:       return (pm && !pa) ? 2 : 1;
      2:       return pa ? 6 : (pm ? 0 : 2);
      4:       return (pa || to) ? 0 : 4;
      6:       return (pa || to) ? 2 : 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input bit m, input bit a);
    bit pm, pa, to, adj;
    int nxt;
    if (reset) begin
      hist_m = '0; hist_a = '0; mdb_m = 0; mdb_a = 0;
      m_mode = 0; m_troca = 0; m_idle = 0;
    end else begin
      hist_m = {hist_m[D:0], m};
      hist_a = {hist_a[D:0], a};
      pm = 0; pa = 0;
      if (settled(hist_m, mdb_m)) begin pm = !mdb_m; mdb_m = !mdb_m; end
      if (settled(hist_a, mdb_a)) begin pa = !mdb_a; mdb_a = !mdb_a; end
      adj = (m_mode >= 4);
      to  = 0;
`ifdef SELETOR_AUTO_RETORNO_EN
      to = adj && (m_idle == T - 1) && !pm && !pa;
`endif
      nxt     = next_mode(m_mode, pm, pa, to);
      m_troca = (nxt != m_mode);
      m_idle  = (pm || pa || !adj || to) ? 0 : m_idle + 1;
      m_mode  = nxt;
    end
  endtask

  task automatic tick(input bit m, input bit a);
    ifc.btn_modo   = m;
    ifc.btn_ajuste = a;
    @(posedge clk);
    model_edge(m, a);
    @(negedge clk);
    chk("code",  {ifc.SW2, ifc.SW1, ifc.SW0}, m_mode);
    chk("ajuste_ativo", ifc.ajuste_ativo, (m_mode >= 4) ? 1 : 0);
    chk("troca", ifc.troca, m_troca);
  endtask

  task automatic ticks(input int n, input bit m, input bit a);
    for (int i = 0; i < n; i++) tick(m, a);
  endtask

  task automatic press_btn(input bit m, input bit a);
    ticks(8, m, a);
    ticks(8, 0, 0);
  endtask

  function automatic logic [2:0] code();
    return {ifc.SW2, ifc.SW1, ifc.SW0};
  endfunction

  initial begin
    bit bm, ba;
    reset = 1'b1;
    ticks(3, 0, 0);
    reset = 1'b0;
    ticks(5, 0, 0);
    chk("rst_code", code(), 3'b000);
    chk("rst_troca", ifc.troca, 1'b0);
    chk("rst_aj", ifc.ajuste_ativo, 1'b0);

    // held mode button: code changes on edge D+1 counted from the first sampling edge
    ticks(5, 1, 0);
    chk("hold_before", code(), 3'b000);
    ticks(1, 1, 0);
    chk("hold_code", code(), 3'b001);
    chk("hold_troca", ifc.troca, 1'b1);
    ticks(1, 1, 0);
    chk("hold_troca_clr", ifc.troca, 1'b0);
    ticks(8, 0, 0);
    press_btn(1, 0);
    chk("seq_timer", code(), 3'b010);
    press_btn(1, 0);
    chk("seq_relogio", code(), 3'b000);

    ticks(3, 1, 0);
    ticks(10, 0, 0);
    chk("glitch_code", code(), 3'b000);

    press_btn(1, 0);
    press_btn(1, 0);
    press_btn(0, 1);
    chk("aj_timer", code(), 3'b110);
    chk("aj_timer_aj", ifc.ajuste_ativo, 1'b1);
    press_btn(1, 0);
    chk("aj_timer_modo", code(), 3'b110);
    press_btn(0, 1);
    chk("aj_timer_exit", code(), 3'b010);
    press_btn(1, 0);
    press_btn(1, 1);
    chk("simult", code(), 3'b100);
    press_btn(0, 1);
    press_btn(1, 0);
    press_btn(0, 1);
    chk("crono_aj", code(), 3'b001);
    press_btn(1, 0);
    press_btn(1, 0);
    chk("back_home", code(), 3'b000);

    ticks(6, 0, 1);
    chk("enter_aj", code(), 3'b100);
`ifdef SELETOR_AUTO_RETORNO_EN
    ticks(19, 0, 0);
    chk("tmo_before", code(), 3'b100);
    ticks(1, 0, 0);
    chk("tmo_code", code(), 3'b000);
    chk("tmo_troca", ifc.troca, 1'b1);
    ticks(8, 0, 0);
    ticks(6, 0, 1);
    chk("reenter_aj", code(), 3'b100);
    ticks(4, 0, 0);
    ticks(25, 1, 0);
    chk("tmo_restart_before", code(), 3'b100);
    ticks(1, 1, 0);
    chk("tmo_restart_code", code(), 3'b000);
    ticks(8, 0, 0);
`else
    ticks(100, 0, 0);
    chk("no_tmo", code(), 3'b100);
    press_btn(0, 1);
    chk("no_tmo_exit", code(), 3'b000);
`endif

    bm = 0;
    ba = 0;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) bm = ~bm;
      if ($urandom_range(0, 7) == 0) ba = ~ba;
      tick(bm, ba);
    end
    reset = 1'b0;
    ticks(4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
